// File: rtl/ready_qualifier.sv
// Multi-channel readiness qualifier: synchronise slow "ready" pads, qualify
// on sustained highs, ride through short lows, count absorbed glitches.
module ready_qualifier #(
   parameter int NUM_CH      = 1,
   parameter int RISE_CYCLES = 1000,
   parameter int FALL_CYCLES = 0,
   parameter int SYNC_STAGES = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NUM_CH-1:0]   sig_in,
   input  logic [NUM_CH-1:0]   glitch_clr,
   output logic [NUM_CH-1:0]   ready,
   output logic [NUM_CH-1:0]   rise,
   output logic [NUM_CH-1:0]   fall,
   output logic                all_ready,
   output logic [8*NUM_CH-1:0] glitch_cnt
);

   localparam int MAX_C = (RISE_CYCLES > FALL_CYCLES) ? RISE_CYCLES
                                                      : FALL_CYCLES;
   localparam int CNT_W = $clog2(MAX_C + 1);

   localparam logic [CNT_W-1:0] RISE_M1 = CNT_W'(RISE_CYCLES - 1);
   localparam logic [CNT_W-1:0] FALL_L  = CNT_W'(FALL_CYCLES);
   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

   typedef enum logic [1:0] {
      S_LOW,
      S_ARM,
      S_UP,
      S_HOLD
   } state_t;

   logic [SYNC_STAGES-1:0] sync_q  [NUM_CH];
   logic [SYNC_STAGES-1:0] sync_d  [NUM_CH];
   state_t                 state_q [NUM_CH];
   state_t                 state_d [NUM_CH];
   logic [CNT_W-1:0]       cnt_q   [NUM_CH];
   logic [CNT_W-1:0]       cnt_d   [NUM_CH];

   logic [NUM_CH-1:0]   s;
   logic [NUM_CH-1:0]   ready_q, ready_d;
   logic [NUM_CH-1:0]   rise_q, rise_d;
   logic [NUM_CH-1:0]   fall_q, fall_d;
   logic                all_ready_q, all_ready_d;
   logic [8*NUM_CH-1:0] gcnt_q, gcnt_d;

   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         s[i] = sync_q[i][SYNC_STAGES-1];
      end
   end

   always_comb begin
      all_ready_d = &ready_q;
      for (int i = 0; i < NUM_CH; i++) begin
         sync_d[i]          = {sync_q[i][SYNC_STAGES-2:0], sig_in[i]};
         state_d[i]         = state_q[i];
         cnt_d[i]           = cnt_q[i];
         rise_d[i]          = 1'b0;
         fall_d[i]          = 1'b0;
         gcnt_d[8*i +: 8]   = gcnt_q[8*i +: 8];

         unique case (state_q[i])
            S_LOW: begin
               if (s[i]) begin
                  cnt_d[i] = ONE;
                  if (RISE_CYCLES == 1) begin
                     state_d[i] = S_UP;
                     rise_d[i]  = 1'b1;
                  end else begin
                     state_d[i] = S_ARM;
                  end
               end else begin
                  cnt_d[i] = '0;
               end
            end
            S_ARM: begin
               if (!s[i]) begin
                  state_d[i] = S_LOW;
                  cnt_d[i]   = '0;
               end else begin
                  cnt_d[i] = cnt_q[i] + ONE;
                  if (cnt_q[i] == RISE_M1) begin
                     state_d[i] = S_UP;
                     rise_d[i]  = 1'b1;
                  end
               end
            end
            S_UP: begin
               if (!s[i]) begin
                  if (FALL_CYCLES == 0) begin
                     state_d[i] = S_LOW;
                     cnt_d[i]   = '0;
                     fall_d[i]  = 1'b1;
                  end else begin
                     state_d[i] = S_HOLD;
                     cnt_d[i]   = ONE;
                  end
               end
            end
            S_HOLD: begin
               if (s[i]) begin
                  // low run ended before the drop threshold: absorbed glitch
                  state_d[i] = S_UP;
                  cnt_d[i]   = '0;
                  if (gcnt_q[8*i +: 8] != 8'hFF) begin
                     gcnt_d[8*i +: 8] = gcnt_q[8*i +: 8] + 8'd1;
                  end
               end else if (cnt_q[i] == FALL_L) begin
                  state_d[i] = S_LOW;
                  cnt_d[i]   = '0;
                  fall_d[i]  = 1'b1;
               end else begin
                  cnt_d[i] = cnt_q[i] + ONE;
               end
            end
         endcase

         ready_d[i] = (state_d[i] == S_UP) || (state_d[i] == S_HOLD);
         if (glitch_clr[i]) begin
            gcnt_d[8*i +: 8] = 8'h00;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_CH; i++) begin
            sync_q[i]  <= '0;
            state_q[i] <= S_LOW;
            cnt_q[i]   <= '0;
         end
         ready_q     <= '0;
         rise_q      <= '0;
         fall_q      <= '0;
         all_ready_q <= 1'b0;
         gcnt_q      <= '0;
      end else begin
         sync_q      <= sync_d;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         ready_q     <= ready_d;
         rise_q      <= rise_d;
         fall_q      <= fall_d;
         all_ready_q <= all_ready_d;
         gcnt_q      <= gcnt_d;
      end
   end

   assign ready      = ready_q;
   assign rise       = rise_q;
   assign fall       = fall_q;
   assign all_ready  = all_ready_q;
   assign glitch_cnt = gcnt_q;

endmodule
